// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART-to-Wishbone command path: command sub-codes,
// default frame sync tag, decoder state encoding and the 34-bit command word.
package wb_uart_pkg;

    localparam logic [1:0] CMD_SUB_RD      = 2'b00;
    localparam logic [1:0] CMD_SUB_WR      = 2'b01;
    localparam logic [1:0] CMD_SUB_ADDR    = 2'b10;
    localparam logic [1:0] CMD_SUB_SPECIAL = 2'b11;

    // Header byte is {SYNC_TAG, sub}, so valid headers are 0xA8..0xAB by default.
    localparam logic [5:0] SYNC_TAG_DEFAULT = 6'h2A;

    typedef enum logic {
        S_IDLE,
        S_DATA
    } dec_state_t;

    // {sub[1:0], data[31:0]}
    typedef logic [33:0] cmd_word_t;

    // True when the upper six bits of a received byte carry the sync tag.
    function automatic logic is_header(input logic [7:0] rx_byte, input logic [5:0] tag);
        return (rx_byte[7:2] == tag);
    endfunction

endpackage : wb_uart_pkg

// File: rtl/wb_cmd_decoder.sv
// Assembles UART RX bytes into 34-bit command words and presents them on a
// stb/busy handshake. A frame is a header byte {SYNC_TAG, sub} followed by
// no payload (RD) or four payload bytes MSB first (WR/ADDR/SPECIAL).
// Bad headers and inter-byte timeouts pulse o_frame_err; a completed word
// that cannot be stored because the previous one is still pending pulses
// o_overrun and is dropped.
module wb_cmd_decoder
    import wb_uart_pkg::*;
#(
    parameter logic [5:0] SYNC_TAG    = SYNC_TAG_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    output logic        o_cmd_stb,
    output logic [33:0] o_cmd_word,
    input  logic        i_cmd_busy,
    output logic        o_frame_err,
    output logic        o_overrun,
    output logic        o_idle
);

    localparam int             TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

    // Frame assembly state
    dec_state_t       state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    // Only the first three payload bytes need storing; the fourth is taken
    // straight from i_rx_data when the word completes.
    logic [23:0]      shift_q, shift_d;
    logic [1:0]       sub_q, sub_d;
    logic             frame_err_q, frame_err_d;

    // One-deep output register
    logic             stb_q, stb_d;
    cmd_word_t        word_q, word_d;
    logic             overrun_q, overrun_d;

    // Completion strobe from the FSM to the output register
    logic             word_done;
    cmd_word_t        word_val;
    logic             accept;

    // Next-state logic: header check, payload shifting and inter-byte timeout.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        shift_d     = shift_q;
        sub_d       = sub_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        word_val    = '0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_stb) begin
                    if (is_header(i_rx_data, SYNC_TAG)) begin
                        if (i_rx_data[1:0] == CMD_SUB_RD) begin
                            // Reads carry no payload: word completes on the header.
                            word_done = 1'b1;
                            word_val  = {CMD_SUB_RD, 32'h0};
                        end else begin
                            sub_d      = i_rx_data[1:0];
                            byte_cnt_d = 2'd0;
                            tmo_cnt_d  = '0;
                            state_d    = S_DATA;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (i_rx_stb) begin
                    // A byte arriving on the timeout cycle still counts.
                    shift_d    = {shift_q[15:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    tmo_cnt_d  = '0;
                    if (byte_cnt_q == 2'd3) begin
                        word_done = 1'b1;
                        word_val  = {sub_q, shift_q, i_rx_data};
                        state_d   = S_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    tmo_cnt_d   = '0;
                    byte_cnt_d  = 2'd0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame assembly registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            tmo_cnt_q   <= '0;
            shift_q     <= '0;
            sub_q       <= CMD_SUB_RD;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            shift_q     <= shift_d;
            sub_q       <= sub_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Output register: load a finished word if the slot is free or being
    // accepted this cycle, otherwise drop it and flag the overrun.
    always_comb begin
        accept    = stb_q & ~i_cmd_busy;
        stb_d     = stb_q;
        word_d    = word_q;
        overrun_d = 1'b0;

        if (word_done) begin
            if (!stb_q || accept) begin
                stb_d  = 1'b1;
                word_d = word_val;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            stb_d = 1'b0;
        end
    end

    // Output handshake registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stb_q     <= 1'b0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            stb_q     <= stb_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_cmd_stb   = stb_q;
    assign o_cmd_word  = word_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_idle      = (state_q == S_IDLE);

endmodule : wb_cmd_decoder
